// File: rtl/program_memory_loader_pkg.sv
// rtl/program_memory_loader_pkg.sv - shared types and constants for the BIP program memory loader
package program_memory_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE
  } state_t;

  function automatic int bytes_per_word(input int data_bits);
    return data_bits / BYTE_BITS;
  endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// rtl/program_memory_loader_if.sv - byte-serial program stream from host to loader
interface program_memory_loader_if;
  import program_memory_pkg::*;

  logic [BYTE_BITS-1:0] i_byte;
  logic                 i_byte_valid;
  logic                 o_byte_ready;

  modport master (output i_byte, output i_byte_valid, input o_byte_ready);
  modport slave  (input i_byte, input i_byte_valid, output o_byte_ready);

endinterface

// File: rtl/program_memory_loader_word_assembler.sv
// rtl/program_memory_loader_word_assembler.sv - MSB-first byte shift register building one program word
module word_assembler
  import program_memory_pkg::*;
#(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_accept,
  input  logic [BYTE_BITS-1:0] byte_data,
  output logic [DATA_BITS-1:0] word,
  output logic                 word_complete
);

  localparam int BPW = bytes_per_word(DATA_BITS);
  localparam int CW  = $clog2(BPW + 1);

  logic [CW-1:0] byte_count;

  // Asserted together with the accept of the final byte so the FSM can enter WRITE next edge.
  assign word_complete = byte_accept && (byte_count == CW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= '0;
      word       <= '0;
    end else if (clear) begin
      byte_count <= '0;
    end else if (byte_accept) begin
      byte_count <= byte_count + CW'(1);
      word       <= (word << BYTE_BITS) | DATA_BITS'(byte_data);
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - BIP program memory with registered fetch port and byte-serial boot loader
module program_memory_loader
  import program_memory_pkg::*;
#(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [ADDRESS_BITS-1:0] i_address,
  input  logic                    i_read_enable,
  output logic [DATA_BITS-1:0]    o_data,
  input  logic                    i_load_start,
  input  logic [ADDRESS_BITS:0]   i_load_length,
  program_memory_loader_if.slave  byte_bus,
  output logic                    o_loading,
  output logic                    o_load_done,
  output logic                    o_load_error,
  output logic [ADDRESS_BITS:0]   o_word_count
);

  localparam int                  DEPTH   = 2 ** ADDRESS_BITS;
  localparam logic [ADDRESS_BITS:0] MAX_LEN = (ADDRESS_BITS + 1)'(DEPTH);

  state_t                  state, state_next;
  logic [ADDRESS_BITS:0]   length_q;
  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic [DATA_BITS-1:0]    word;
  logic                    word_complete;
  logic                    byte_accept;
  logic                    fetch_active;
  logic                    length_ok;
  logic                    start_ok;
  logic                    start_bad;
  logic                    last_word;
  logic                    clear;

  assign fetch_active          = (state == IDLE) || (state == DONE);
  assign o_loading             = (state == RECEIVE) || (state == WRITE);
  assign byte_bus.o_byte_ready = (state == RECEIVE);
  assign byte_accept           = byte_bus.i_byte_valid && byte_bus.o_byte_ready;
  assign length_ok             = (i_load_length != '0) && (i_load_length <= MAX_LEN);
  assign start_ok              = fetch_active && i_load_start && length_ok;
  assign start_bad             = fetch_active && i_load_start && !length_ok;
  assign last_word             = (o_word_count + (ADDRESS_BITS + 1)'(1)) == length_q;
  assign clear                 = (state == WRITE) || start_ok;

  word_assembler #(.DATA_BITS(DATA_BITS)) u_word_assembler (
    .clk          (clk),
    .rst_n        (i_rst_n),
    .clear        (clear),
    .byte_accept  (byte_accept),
    .byte_data    (byte_bus.i_byte),
    .word         (word),
    .word_complete(word_complete)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = RECEIVE;
      RECEIVE:    if (word_complete) state_next = WRITE;
      WRITE:      state_next = last_word ? DONE : RECEIVE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      length_q     <= '0;
      o_word_count <= '0;
      o_load_done  <= 1'b0;
      o_load_error <= 1'b0;
      o_data       <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        length_q     <= i_load_length;
        o_word_count <= '0;
        o_load_done  <= 1'b0;
        o_load_error <= 1'b0;
      end else if (start_bad) begin
        o_load_error <= 1'b1;
      end
      if (state == WRITE) begin
        o_word_count <= o_word_count + (ADDRESS_BITS + 1)'(1);
        if (last_word) o_load_done <= 1'b1;
      end
      // The CPU sees NOPs while a program is being streamed in.
      if (o_loading) begin
        o_data <= '0;
      end else if (i_read_enable) begin
        o_data <= mem[i_address];
      end
    end
  end

  // Contents deliberately survive reset; the word counter doubles as the write address.
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      mem[o_word_count[ADDRESS_BITS-1:0]] <= word;
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - directed self-checking bench for program_memory_loader
module tb_program_memory_loader;

  localparam int AB = 11;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AB-1:0] address;
  logic          read_enable;
  logic [DB-1:0] data;
  logic          load_start;
  logic [AB:0]   load_length;
  logic          loading;
  logic          load_done;
  logic          load_error;
  logic [AB:0]   word_count;

  int tests_run    = 0;
  int tests_failed = 0;

  program_memory_loader_if bus ();

  program_memory_loader #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_address    (address),
    .i_read_enable(read_enable),
    .o_data       (data),
    .i_load_start (load_start),
    .i_load_length(load_length),
    .byte_bus     (bus),
    .o_loading    (loading),
    .o_load_done  (load_done),
    .o_load_error (load_error),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int waited;
    repeat (stall) tick();
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    waited = 0;
    while (bus.o_byte_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) check("byte_ready_timeout", 32'd0, 32'd1);
    tick();
    bus.i_byte_valid = 1'b0;
  endtask

  // Returns in the WRITE cycle that follows the second byte.
  task automatic send_word(input logic [15:0] w, input int max_stall, input string tag);
    send_byte(w[15:8], $urandom_range(0, max_stall));
    send_byte(w[7:0], $urandom_range(0, max_stall));
    check({tag, "_write_ready_low"}, 32'(bus.o_byte_ready), 32'd0);
    check({tag, "_write_loading"}, 32'(loading), 32'd1);
  endtask

  task automatic start(input logic [AB:0] len);
    load_length = len;
    load_start  = 1'b1;
    tick();
    load_start  = 1'b0;
  endtask

  task automatic fetch(input logic [AB-1:0] a, input logic [15:0] exp, input string tag);
    address     = a;
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    check(tag, 32'(data), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    address          = '0;
    read_enable      = 1'b0;
    load_start       = 1'b0;
    load_length      = '0;
    bus.i_byte       = '0;
    bus.i_byte_valid = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(data), 32'd0);
    check("rst_ready", 32'(bus.o_byte_ready), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_loading", 32'(loading), 32'd0);

    // Plain load of three words, no stalls
    start(12'd3);
    check("l1_loading", 32'(loading), 32'd1);
    check("l1_ready_after_start", 32'(bus.o_byte_ready), 32'd1);
    send_word(16'h1234, 0, "l1_w0");
    send_word(16'h5678, 0, "l1_w1");
    send_word(16'h9ABC, 0, "l1_w2");
    check("l1_done_in_last_write", 32'(load_done), 32'd0);
    tick();
    check("l1_done", 32'(load_done), 32'd1);
    check("l1_loading_off", 32'(loading), 32'd0);
    check("l1_count", 32'(word_count), 32'd3);
    fetch(11'd0, 16'h1234, "l1_fetch0");
    fetch(11'd1, 16'h5678, "l1_fetch1");
    fetch(11'd2, 16'h9ABC, "l1_fetch2");
    tick();
    check("l1_fetch_hold", 32'(data), 32'h9ABC);

    // Stalled load; a second start and a fetch arrive mid-session
    start(12'd3);
    check("l2_done_cleared", 32'(load_done), 32'd0);
    send_word(16'hA1B2, 2, "l2_w0");
    tick();
    load_length = 12'd1;
    load_start  = 1'b1;
    address     = 11'd0;
    read_enable = 1'b1;
    tick();
    load_start  = 1'b0;
    read_enable = 1'b0;
    check("l2_fetch_during_load", 32'(data), 32'd0);
    check("l2_restart_ignored", 32'(loading), 32'd1);
    send_word(16'hC3D4, 2, "l2_w1");
    tick();
    check("l2_still_loading", 32'(loading), 32'd1);
    check("l2_count_mid", 32'(word_count), 32'd2);
    send_word(16'hE5F6, 2, "l2_w2");
    tick();
    check("l2_done", 32'(load_done), 32'd1);
    check("l2_count", 32'(word_count), 32'd3);
    fetch(11'd0, 16'hA1B2, "l2_fetch0");
    fetch(11'd1, 16'hC3D4, "l2_fetch1");
    fetch(11'd2, 16'hE5F6, "l2_fetch2");

    // Rejected lengths
    start(12'd0);
    check("len0_error", 32'(load_error), 32'd1);
    check("len0_loading", 32'(loading), 32'd0);
    start(12'd2049);
    check("len_over_error", 32'(load_error), 32'd1);
    check("len_over_loading", 32'(loading), 32'd0);
    fetch(11'd0, 16'hA1B2, "reject_mem_unchanged");

    // Full-depth length is legal
    start(12'd2048);
    check("depth_error_cleared", 32'(load_error), 32'd0);
    check("depth_loading", 32'(loading), 32'd1);
    check("depth_count", 32'(word_count), 32'd0);

    // Reset after one and a half words
    send_word(16'h1111, 0, "rst_w0");
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_loading", 32'(loading), 32'd0);
    check("midrst_ready", 32'(bus.o_byte_ready), 32'd0);
    check("midrst_done", 32'(load_done), 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch(11'd0, 16'h1111, "midrst_word0_kept");
    fetch(11'd1, 16'hC3D4, "midrst_word1_unchanged");
    check("midrst_done_after", 32'(load_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
